// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I instruction decoder with a one-deep registered output stage and
//   valid/ready handshaking on both sides. Decode is purely combinational from
//   instr; the result is captured on an accepted transfer, so out_valid rises
//   exactly one cycle after the instruction is taken.
//
//   Optional feature: define RV32M_EN to decode the M extension
//   (OP with funct7 = 0000001). Without it those encodings are illegal.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   instr, in_valid       instruction in, qualified by in_valid
//   in_ready              stage can accept (output slot empty or draining)
//   flush                 drop the held result and block capture this cycle
//   out_valid, out_ready  result handshake
//   ALUOp .. ALUSelect    decoded control fields
//   rs1, rs2, rd          raw register fields (always extracted)
//   imm                   sign-extended immediate for the instruction format
//   illegal               result is an illegal instruction (controls zeroed)
//   illegal_count         saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int DATA_WIDTH        = 32,
  parameter int ALUOP_WIDTH       = 5,
  parameter int TYPE_WIDTH        = 3,
  parameter int DTYPE_WIDTH       = 3,
  parameter int BRANCH_TYPE_WIDTH = 3,
  parameter int ALUSELECT_WIDTH   = 2,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        instr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [ALUOP_WIDTH-1:0]       ALUOp,
  output logic [TYPE_WIDTH-1:0]        rawType,
  output logic                         load,
  output logic [DTYPE_WIDTH-1:0]       dType,
  output logic                         MWE,
  output logic                         RWE,
  output logic [BRANCH_TYPE_WIDTH-1:0] branchType,
  output logic                         jump,
  output logic [ALUSELECT_WIDTH-1:0]   ALUSelect,
  output logic [4:0]                   rs1,
  output logic [4:0]                   rs2,
  output logic [4:0]                   rd,
  output logic [DATA_WIDTH-1:0]        imm,
  output logic                         illegal,
  output logic [COUNT_WIDTH-1:0]       illegal_count
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [ALUOP_WIDTH-1:0] ALU_NONE = ALUOP_WIDTH'(0);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SLL  = ALUOP_WIDTH'(1);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SRL  = ALUOP_WIDTH'(2);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SRA  = ALUOP_WIDTH'(3);
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = ALUOP_WIDTH'(4);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB  = ALUOP_WIDTH'(5);
  localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = ALUOP_WIDTH'(6);
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = ALUOP_WIDTH'(7);
  localparam logic [ALUOP_WIDTH-1:0] ALU_XOR  = ALUOP_WIDTH'(8);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SLTU = ALUOP_WIDTH'(9);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SLT  = ALUOP_WIDTH'(10);
`ifdef RV32M_EN
  localparam logic [6:0]             F7_MULDIV = 7'b0000001;
  // MUL..REMU are consecutive codes in funct3 order
  localparam logic [ALUOP_WIDTH-1:0] ALU_MUL   = ALUOP_WIDTH'(11);
`endif

  localparam logic [TYPE_WIDTH-1:0] T_R = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] T_I = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] T_S = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] T_B = TYPE_WIDTH'(3);
  localparam logic [TYPE_WIDTH-1:0] T_U = TYPE_WIDTH'(4);
  localparam logic [TYPE_WIDTH-1:0] T_J = TYPE_WIDTH'(5);

  localparam logic [DTYPE_WIDTH-1:0] DT_BU = DTYPE_WIDTH'(3);
  localparam logic [DTYPE_WIDTH-1:0] DT_HU = DTYPE_WIDTH'(4);

  localparam logic [BRANCH_TYPE_WIDTH-1:0] BR_BEQ  = BRANCH_TYPE_WIDTH'(0);
  localparam logic [BRANCH_TYPE_WIDTH-1:0] BR_BNE  = BRANCH_TYPE_WIDTH'(1);
  localparam logic [BRANCH_TYPE_WIDTH-1:0] BR_BLT  = BRANCH_TYPE_WIDTH'(2);
  localparam logic [BRANCH_TYPE_WIDTH-1:0] BR_BGE  = BRANCH_TYPE_WIDTH'(3);
  localparam logic [BRANCH_TYPE_WIDTH-1:0] BR_BLTU = BRANCH_TYPE_WIDTH'(4);
  localparam logic [BRANCH_TYPE_WIDTH-1:0] BR_BGEU = BRANCH_TYPE_WIDTH'(5);

  localparam logic [ALUSELECT_WIDTH-1:0] SEL_NONE = ALUSELECT_WIDTH'(0);
  localparam logic [ALUSELECT_WIDTH-1:0] SEL_IALU = ALUSELECT_WIDTH'(1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // ALU operation for OP / OP-IMM. Returns {bad, aluop}. For OP-IMM the
  // funct7 field is immediate data except on shifts, where it selects SRL/SRA.
  function automatic logic [ALUOP_WIDTH:0] alu_decode(input logic [2:0] f3,
                                                      input logic [6:0] f7,
                                                      input logic       is_op);
    logic [ALUOP_WIDTH-1:0] op;
    logic                   bad;
    op  = ALU_NONE;
    bad = 1'b0;
    case (f3)
      3'b000: begin
        op  = (is_op && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
        bad = is_op && (f7 != F7_ZERO) && (f7 != F7_ALT);
      end
      3'b001: begin op = ALU_SLL;  bad = (f7 != F7_ZERO);          end
      3'b010: begin op = ALU_SLT;  bad = is_op && (f7 != F7_ZERO); end
      3'b011: begin op = ALU_SLTU; bad = is_op && (f7 != F7_ZERO); end
      3'b100: begin op = ALU_XOR;  bad = is_op && (f7 != F7_ZERO); end
      3'b101: begin
        op  = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        bad = (f7 != F7_ZERO) && (f7 != F7_ALT);
      end
      3'b110: begin op = ALU_OR;   bad = is_op && (f7 != F7_ZERO); end
      default: begin op = ALU_AND; bad = is_op && (f7 != F7_ZERO); end
    endcase
    return {bad, op};
  endfunction

  // Combinational decode
  logic [ALUOP_WIDTH-1:0]       d_aluop, c_aluop;
  logic [TYPE_WIDTH-1:0]        d_type;
  logic                         d_load, d_mwe, d_rwe, d_jump, d_ill;
  logic                         c_load, c_mwe, c_rwe, c_jump;
  logic [DTYPE_WIDTH-1:0]       d_dtype;
  logic [BRANCH_TYPE_WIDTH-1:0] d_btype;
  logic [ALUSELECT_WIDTH-1:0]   c_sel;
  logic [DATA_WIDTH-1:0]        d_imm;

  always_comb begin
    d_aluop = ALU_NONE;
    d_type  = T_R;
    d_load  = 1'b0;
    d_dtype = '0;
    d_mwe   = 1'b0;
    d_rwe   = 1'b0;
    d_btype = '0;
    d_jump  = 1'b0;
    d_ill   = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        d_type = T_U; d_aluop = ALU_ADD; d_rwe = 1'b1;
      end
      OPC_JAL: begin
        d_type = T_J; d_jump = 1'b1; d_rwe = 1'b1;
      end
      OPC_JALR: begin
        d_type = T_I; d_aluop = ALU_ADD; d_jump = 1'b1; d_rwe = 1'b1;
        d_ill  = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_type = T_B; d_aluop = ALU_SUB;
        case (funct3)
          3'b000:  d_btype = BR_BEQ;
          3'b001:  d_btype = BR_BNE;
          3'b100:  d_btype = BR_BLT;
          3'b101:  d_btype = BR_BGE;
          3'b110:  d_btype = BR_BLTU;
          3'b111:  d_btype = BR_BGEU;
          default: d_ill   = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_type = T_I; d_aluop = ALU_ADD; d_load = 1'b1; d_rwe = 1'b1;
        case (funct3)
          3'b000, 3'b001, 3'b010: d_dtype = DTYPE_WIDTH'(funct3);
          3'b100:                 d_dtype = DT_BU;
          3'b101:                 d_dtype = DT_HU;
          default:                d_ill   = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d_type = T_S; d_aluop = ALU_ADD; d_mwe = 1'b1;
        // B/H/W share the funct3 encoding with the dType codes
        if (funct3 <= 3'b010) d_dtype = DTYPE_WIDTH'(funct3);
        else                  d_ill   = 1'b1;
      end
      OPC_OPIMM: begin
        d_type = T_I; d_rwe = 1'b1;
        {d_ill, d_aluop} = alu_decode(funct3, funct7, 1'b0);
      end
      OPC_OP: begin
        d_type = T_R; d_rwe = 1'b1;
`ifdef RV32M_EN
        if (funct7 == F7_MULDIV) d_aluop = ALU_MUL + ALUOP_WIDTH'(funct3);
        else                     {d_ill, d_aluop} = alu_decode(funct3, funct7, 1'b1);
`else
        {d_ill, d_aluop} = alu_decode(funct3, funct7, 1'b1);
`endif
      end
      default: d_ill = 1'b1;  // includes compressed encodings (instr[1:0] != 11)
    endcase
  end

  // Illegal instructions keep their format fields but lose every side effect
  always_comb begin
    c_aluop = d_ill ? ALU_NONE : d_aluop;
    c_load  = d_load & ~d_ill;
    c_mwe   = d_mwe  & ~d_ill;
    c_rwe   = d_rwe  & ~d_ill;
    c_jump  = d_jump & ~d_ill;
    c_sel   = d_ill ? SEL_NONE : SEL_IALU;
  end

  always_comb begin
    d_imm = '0;
    case (d_type)
      T_I: d_imm = DATA_WIDTH'($signed(instr[31:20]));
      T_S: d_imm = DATA_WIDTH'($signed({instr[31:25], instr[11:7]}));
      T_B: d_imm = DATA_WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      T_U: d_imm = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
      T_J: d_imm = DATA_WIDTH'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: d_imm = '0;
    endcase
  end

  // Output register stage
  logic                         valid_reg;
  logic [ALUOP_WIDTH-1:0]       aluop_reg;
  logic [TYPE_WIDTH-1:0]        type_reg;
  logic                         load_reg, mwe_reg, rwe_reg, jump_reg, ill_reg;
  logic [DTYPE_WIDTH-1:0]       dtype_reg;
  logic [BRANCH_TYPE_WIDTH-1:0] btype_reg;
  logic [ALUSELECT_WIDTH-1:0]   sel_reg;
  logic [4:0]                   rs1_reg, rs2_reg, rd_reg;
  logic [DATA_WIDTH-1:0]        imm_reg;
  logic [COUNT_WIDTH-1:0]       cnt_reg;

  assign in_ready = !valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      aluop_reg <= '0;
      type_reg  <= '0;
      load_reg  <= 1'b0;
      dtype_reg <= '0;
      mwe_reg   <= 1'b0;
      rwe_reg   <= 1'b0;
      btype_reg <= '0;
      jump_reg  <= 1'b0;
      sel_reg   <= '0;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      rd_reg    <= '0;
      imm_reg   <= '0;
      ill_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (flush) begin
      // flush wins over a simultaneous transfer: nothing is captured or counted
      valid_reg <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_reg <= 1'b1;
      aluop_reg <= c_aluop;
      type_reg  <= d_type;
      load_reg  <= c_load;
      dtype_reg <= d_dtype;
      mwe_reg   <= c_mwe;
      rwe_reg   <= c_rwe;
      btype_reg <= d_btype;
      jump_reg  <= c_jump;
      sel_reg   <= c_sel;
      rs1_reg   <= instr[19:15];
      rs2_reg   <= instr[24:20];
      rd_reg    <= instr[11:7];
      imm_reg   <= d_imm;
      ill_reg   <= d_ill;
      if (d_ill && cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid     = valid_reg;
  assign ALUOp         = aluop_reg;
  assign rawType       = type_reg;
  assign load          = load_reg;
  assign dType         = dtype_reg;
  assign MWE           = mwe_reg;
  assign RWE           = rwe_reg;
  assign branchType    = btype_reg;
  assign jump          = jump_reg;
  assign ALUSelect     = sel_reg;
  assign rs1           = rs1_reg;
  assign rs2           = rs2_reg;
  assign rd            = rd_reg;
  assign imm           = imm_reg;
  assign illegal       = ill_reg;
  assign illegal_count = cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Scoreboard bench for decode_stage. Expected results are queued when an
//   instruction is accepted and compared when the result is consumed.
//   A second instance with COUNT_WIDTH=2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, flush, out_ready, out_valid;
  logic [31:0] instr;
  logic [4:0]  ALUOp;
  logic [2:0]  rawType, dType, branchType;
  logic        load, MWE, RWE, jump, illegal;
  logic [1:0]  ALUSelect;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [15:0] illegal_count;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .ALUOp(ALUOp),
    .rawType(rawType), .load(load), .dType(dType), .MWE(MWE), .RWE(RWE),
    .branchType(branchType), .jump(jump), .ALUSelect(ALUSelect), .rs1(rs1),
    .rs2(rs2), .rd(rd), .imm(imm), .illegal(illegal), .illegal_count(illegal_count)
  );

  // Saturation instance
  logic        s_in_valid, s_in_ready, s_flush, s_out_ready, s_out_valid;
  logic [31:0] s_instr;
  logic [4:0]  s_ALUOp;
  logic [2:0]  s_rawType, s_dType, s_branchType;
  logic        s_load, s_MWE, s_RWE, s_jump, s_illegal;
  logic [1:0]  s_ALUSelect;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [31:0] s_imm;
  logic [1:0]  s_illegal_count;

  decode_stage #(.COUNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .instr(s_instr), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .flush(s_flush), .out_ready(s_out_ready), .out_valid(s_out_valid), .ALUOp(s_ALUOp),
    .rawType(s_rawType), .load(s_load), .dType(s_dType), .MWE(s_MWE), .RWE(s_RWE),
    .branchType(s_branchType), .jump(s_jump), .ALUSelect(s_ALUSelect), .rs1(s_rs1),
    .rs2(s_rs2), .rd(s_rd), .imm(s_imm), .illegal(s_illegal), .illegal_count(s_illegal_count)
  );

  typedef struct {
    int          idx;
    logic [31:0] instr;
    logic [31:0] aluop, raw, ld, dt, mwe, rwe, bt, jmp, sel;
    logic [31:0] imm;
    logic [31:0] ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_cnt = 0;
  int   n_sent = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic add(input logic [31:0] ins, input int aluop, input int raw, input int ld,
                     input int dt, input int mwe, input int rwe, input int bt, input int jmp,
                     input logic [31:0] im, input int ill);
    exp_t e;
    e.idx = 0; e.instr = ins; e.aluop = aluop; e.raw = raw; e.ld = ld; e.dt = dt;
    e.mwe = mwe; e.rwe = rwe; e.bt = bt; e.jmp = jmp; e.imm = im; e.ill = ill;
    e.sel = (ill != 0) ? 0 : 1;
    e.cnt = 0;
    tbl.push_back(e);
  endtask

  // Offer one instruction; called and returns at posedge+1
  task automatic send(input exp_t e_in);
    exp_t e;
    int   n;
    e = e_in;
    instr = e.instr;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", in_ready, 1);
    if (e.ill != 0 && model_cnt < 65535) model_cnt++;
    e.cnt = model_cnt;
    e.idx = n_sent++;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Consumer side: compare whenever a result is handed over
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        $display("txn %0d instr=%08h alu=%0d type=%0d rwe=%0b ill=%0b cnt=%0d imm=%08h",
                 e.idx, e.instr, ALUOp, rawType, RWE, illegal, illegal_count, imm);
        check($sformatf("t%0d_illegal", e.idx), illegal, e.ill);
        check($sformatf("t%0d_aluop", e.idx), ALUOp, e.aluop);
        check($sformatf("t%0d_load", e.idx), load, e.ld);
        check($sformatf("t%0d_mwe", e.idx), MWE, e.mwe);
        check($sformatf("t%0d_rwe", e.idx), RWE, e.rwe);
        check($sformatf("t%0d_jump", e.idx), jump, e.jmp);
        check($sformatf("t%0d_alusel", e.idx), ALUSelect, e.sel);
        check($sformatf("t%0d_rs1", e.idx), rs1, e.instr[19:15]);
        check($sformatf("t%0d_rs2", e.idx), rs2, e.instr[24:20]);
        check($sformatf("t%0d_rd", e.idx), rd, e.instr[11:7]);
        check($sformatf("t%0d_count", e.idx), illegal_count, e.cnt);
        if (e.ill == 0) begin
          check($sformatf("t%0d_rawtype", e.idx), rawType, e.raw);
          check($sformatf("t%0d_dtype", e.idx), dType, e.dt);
          check($sformatf("t%0d_btype", e.idx), branchType, e.bt);
          check($sformatf("t%0d_imm", e.idx), imm, e.imm);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = '0;
    s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1; s_instr = '0;

    //   instr         alu raw ld dt mwe rwe bt jmp imm           ill
    add(32'h00500093,  4,  1,  0, 0, 0,  1,  0, 0,  32'h5,        0); // addi x1,x0,5
    add(32'hFE000EE3,  5,  3,  0, 0, 0,  0,  0, 0,  32'hFFFFFFFC, 0); // beq x0,x0,-4
    add(32'h00812283,  4,  1,  1, 2, 0,  1,  0, 0,  32'h8,        0); // lw x5,8(x2)
    add(32'hFE30AE23,  4,  2,  0, 2, 1,  0,  0, 0,  32'hFFFFFFFC, 0); // sw x3,-4(x1)
    add(32'h123453B7,  4,  4,  0, 0, 0,  1,  0, 0,  32'h12345000, 0); // lui x7,0x12345
    add(32'h010000EF,  0,  5,  0, 0, 0,  1,  0, 1,  32'h10,       0); // jal x1,16
    add(32'h00008067,  4,  1,  0, 0, 0,  1,  0, 1,  32'h0,        0); // jalr x0,0(x1)
    add(32'h402081B3,  5,  0,  0, 0, 0,  1,  0, 0,  32'h0,        0); // sub x3,x1,x2
    add(32'h40315113,  3,  1,  0, 0, 0,  1,  0, 0,  32'h403,      0); // srai x2,x2,3
    add(32'h0020E463,  5,  3,  0, 0, 0,  0,  4, 0,  32'h8,        0); // bltu x1,x2,8
    add(32'h0000C203,  4,  1,  1, 3, 0,  1,  0, 0,  32'h0,        0); // lbu x4,0(x1)
    add(32'h007362B3,  7,  0,  0, 0, 0,  1,  0, 0,  32'h0,        0); // or x5,x6,x7
    add(32'hFFFFFFFF,  0,  0,  0, 0, 0,  0,  0, 0,  32'h0,        1);
    add(32'hFFFFFFFF,  0,  0,  0, 0, 0,  0,  0, 0,  32'h0,        1);
    add(32'h40209093,  0,  0,  0, 0, 0,  0,  0, 0,  32'h0,        1); // slli with funct7 0100000
    add(32'h0000B203,  0,  0,  0, 0, 0,  0,  0, 0,  32'h0,        1); // load funct3 011
    add(32'h00003023,  0,  0,  0, 0, 0,  0,  0, 0,  32'h0,        1); // store funct3 011
    add(32'h00002063,  0,  0,  0, 0, 0,  0,  0, 0,  32'h0,        1); // branch funct3 010
    add(32'h00000001,  0,  0,  0, 0, 0,  0,  0, 0,  32'h0,        1); // compressed quadrant
`ifdef RV32M_EN
    add(32'h02208033, 11,  0,  0, 0, 0,  1,  0, 0,  32'h0,        0); // mul x0,x1,x2
`else
    add(32'h02208033,  0,  0,  0, 0, 0,  0,  0, 0,  32'h0,        1); // mul without M
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", illegal_count, 0);
    check("rst_imm", imm, 0);
    check("rst_rwe", RWE, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // First instruction: result exactly one cycle later
    send(tbl[0]);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    @(posedge clk); #1;

    foreach (tbl[i]) send(tbl[i]);

    // Backpressure: result held while out_ready is low, next instr waits
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(tbl[0]);
    instr = tbl[1].instr;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_rd_stable", rd, tbl[0].instr[11:7]);
      check("bp_imm_stable", imm, tbl[0].imm);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(tbl[1]);
    repeat (2) @(posedge clk);
    #1;

    // Flush overriding a simultaneous transfer of an illegal instruction
    instr = 32'hFFFFFFFF;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_xfer_valid", out_valid, 0);
    check("flush_xfer_count", illegal_count, model_cnt);
    @(posedge clk); #1;

    // Flush discarding a held result
    out_ready = 1'b0;
    send(tbl[2]);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_held_valid", out_valid, 0);
    void'(sb.pop_back());
    @(posedge clk); #1;

    // Reset mid-stream with in_valid high
    send(tbl[12]);
    rst = 1'b1;
    instr = tbl[0].instr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_count", illegal_count, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_rwe", RWE, 0);
    check("midrst_rd", rd, 0);
    sb.delete();
    model_cnt = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(tbl[0]);
    send(tbl[13]);

    // Saturating counter at COUNT_WIDTH=2
    s_instr = 32'hFFFFFFFF;
    s_in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("sat_count_2", s_illegal_count, 2);
    repeat (3) @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    @(negedge clk);
    check("sat_count_5", s_illegal_count, 3);
    check("sat_illegal", s_illegal, 1);
    check("sat_rwe", s_RWE, 0);

    // Drain scoreboard
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
